// File: rtl/hazard_ctrl_mc.sv
// rtl/hazard_ctrl_mc.sv - pipeline hazard, memory wait-state and interrupt-admission controller
// Optional feature macro: HAZARD_PERF_EN (adds saturating perf_lu/perf_flush/perf_mem counters).
module hazard_ctrl_mc #(
  parameter int REG_W       = 5,
  parameter int LU_DEPTH    = 1,
  parameter int WAIT_STATES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [2:0]       pc_src,
  input  logic             branch_taken,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_mem_rd,
  input  logic [REG_W-1:0] mem_rt,
  input  logic             mem_mem_rd,
  input  logic             mem_access,
  input  logic             irq,
  input  logic             id_noirq,
  output logic [1:0]       if_id_src,
  output logic             if_noirq,
  output logic             id_ex_stall,
  output logic             pc_hold,
  output logic             ex_mem_hold,
  output logic             irq_take
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_lu,
  output logic [31:0]      perf_flush,
  output logic [31:0]      perf_mem
`endif
);

  localparam int WC_W = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(WAIT_STATES);

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MEM,
    SEL_TRAP,
    SEL_LU,
    SEL_CTRL
  } sel_e;

  logic [WC_W-1:0] wcnt;
  logic            irq_pend;
  logic            mem_stall;
  logic            lu_ex;
  logic            lu_mem;
  logic            lu;
  logic            ctrl_op;
  logic            pc_trap;
  logic            pc_redirect;
  logic            req;
  sel_e            sel;

  assign mem_stall   = mem_access && (wcnt != WC_MAX);
  assign pc_trap     = (pc_src == 3'd4) || (pc_src == 3'd5);
  assign pc_redirect = (pc_src == 3'd2) || (pc_src == 3'd3) || ((pc_src == 3'd1) && branch_taken);
  assign req         = irq || irq_pend;
  assign ctrl_op     = ((opcode == 6'h00) && ((funct == 6'h08) || (funct == 6'h09)))
                    || ((opcode >= 6'h01) && (opcode <= 6'h07));

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  always_comb begin
    lu_ex  = ex_mem_rd && (ex_rt != '0)
          && ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
    lu_mem = 1'b0;
    if (LU_DEPTH >= 2) begin
      lu_mem = mem_mem_rd && (mem_rt != '0)
            && ((id_use_rs && (id_rs == mem_rt)) || (id_use_rt && (id_rt == mem_rt)));
    end
    lu = lu_ex || lu_mem;
  end

  always_comb begin
    sel = SEL_NONE;
    if (mem_stall)        sel = SEL_MEM;
    else if (pc_trap)     sel = SEL_TRAP;
    else if (lu)          sel = SEL_LU;
    else if (pc_redirect) sel = SEL_CTRL;
  end

  always_comb begin
    if_id_src   = 2'd0;
    if_noirq    = 1'b0;
    id_ex_stall = 1'b0;
    pc_hold     = 1'b0;
    ex_mem_hold = 1'b0;
    irq_take    = 1'b0;
    case (sel)
      SEL_MEM: begin
        if_id_src   = 2'd2;
        pc_hold     = 1'b1;
        ex_mem_hold = 1'b1;
      end
      SEL_TRAP: if_id_src = 2'd1;
      SEL_LU: begin
        if_id_src   = 2'd2;
        id_ex_stall = 1'b1;
        pc_hold     = 1'b1;
      end
      SEL_CTRL: begin
        if_id_src = 2'd1;
        if_noirq  = 1'b1;
      end
      default: ;
    endcase
    irq_take = req && !id_noirq && !ctrl_op && !mem_stall && !lu && (pc_src < 3'd4);
    if (reset) begin
      if_id_src   = 2'd0;
      if_noirq    = 1'b0;
      id_ex_stall = 1'b0;
      pc_hold     = 1'b0;
      ex_mem_hold = 1'b0;
      irq_take    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt     <= '0;
      irq_pend <= 1'b0;
    end else begin
      wcnt     <= mem_stall ? wcnt + 1'b1 : '0;
      irq_pend <= req && !irq_take;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_lu    <= '0;
      perf_flush <= '0;
      perf_mem   <= '0;
    end else begin
      if ((sel == SEL_LU) && (perf_lu != 32'hFFFF_FFFF))
        perf_lu <= perf_lu + 32'd1;
      if (((sel == SEL_TRAP) || (sel == SEL_CTRL)) && (perf_flush != 32'hFFFF_FFFF))
        perf_flush <= perf_flush + 32'd1;
      if ((sel == SEL_MEM) && (perf_mem != 32'hFFFF_FFFF))
        perf_mem <= perf_mem + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb/tb_hazard_ctrl_mc.sv - directed and random checks of hazard_ctrl_mc against a reference model
module tb_hazard_ctrl_mc;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic [2:0] pc_src;
  logic       branch_taken;
  logic [4:0] id_rs, id_rt, ex_rt, mem_rt;
  logic       id_use_rs, id_use_rt, ex_mem_rd, mem_mem_rd, mem_access, irq, id_noirq;

  logic [1:0] a_src, b_src;
  logic       a_noirq, a_bub, a_ph, a_eh, a_take;
  logic       b_noirq, b_bub, b_ph, b_eh, b_take;
`ifdef HAZARD_PERF_EN
  logic [31:0] a_plu, a_pfl, a_pmem, b_plu, b_pfl, b_pmem;
`endif

  always #5 clk = ~clk;

  // Instance A: EX-only load-use, 3 wait states.  Instance B: EX+MEM load-use, 2 wait states.
  hazard_ctrl_mc #(.REG_W(5), .LU_DEPTH(1), .WAIT_STATES(3)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .pc_src(pc_src),
    .branch_taken(branch_taken), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_rt(ex_rt), .ex_mem_rd(ex_mem_rd), .mem_rt(mem_rt),
    .mem_mem_rd(mem_mem_rd), .mem_access(mem_access), .irq(irq), .id_noirq(id_noirq),
    .if_id_src(a_src), .if_noirq(a_noirq), .id_ex_stall(a_bub), .pc_hold(a_ph),
    .ex_mem_hold(a_eh), .irq_take(a_take)
`ifdef HAZARD_PERF_EN
    , .perf_lu(a_plu), .perf_flush(a_pfl), .perf_mem(a_pmem)
`endif
  );

  hazard_ctrl_mc #(.REG_W(5), .LU_DEPTH(2), .WAIT_STATES(2)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .pc_src(pc_src),
    .branch_taken(branch_taken), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_rt(ex_rt), .ex_mem_rd(ex_mem_rd), .mem_rt(mem_rt),
    .mem_mem_rd(mem_mem_rd), .mem_access(mem_access), .irq(irq), .id_noirq(id_noirq),
    .if_id_src(b_src), .if_noirq(b_noirq), .id_ex_stall(b_bub), .pc_hold(b_ph),
    .ex_mem_hold(b_eh), .irq_take(b_take)
`ifdef HAZARD_PERF_EN
    , .perf_lu(b_plu), .perf_flush(b_pfl), .perf_mem(b_pmem)
`endif
  );

  // Packed as {if_id_src, if_noirq, id_ex_stall, pc_hold, ex_mem_hold, irq_take}
  logic [6:0] pack_a, pack_b;
  assign pack_a = {a_src, a_noirq, a_bub, a_ph, a_eh, a_take};
  assign pack_b = {b_src, b_noirq, b_bub, b_ph, b_eh, b_take};

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: cycles already waited in the current access, and the held interrupt.
  int age_a = 0, age_b = 0, nage_a, nage_b;
  bit pend_a = 0, pend_b = 0, npend_a, npend_b;

  function automatic bit dep(input logic [4:0] dst, input logic ld);
    return ld && dst != 0 && ((id_use_rs && id_rs == dst) || (id_use_rt && id_rt == dst));
  endfunction

  function automatic logic [6:0] model(input int depth, input int ws, input int age,
                                       input bit pend, output int nage, output bit npend);
    bit stall, lu, ctrl, take, req;
    logic [6:0] o;
    if (reset) begin
      nage = 0; npend = 0;
      return 7'd0;
    end
    stall = mem_access && age < ws;
    lu    = dep(ex_rt, ex_mem_rd) || (depth == 2 && dep(mem_rt, mem_mem_rd));
    ctrl  = (opcode == 0 && (funct == 8 || funct == 9)) || (opcode >= 1 && opcode <= 7);
    if (stall)                       o = 7'b1000110;
    else if (pc_src == 4 || pc_src == 5) o = 7'b0100000;
    else if (lu)                     o = 7'b1001100;
    else if (pc_src == 2 || pc_src == 3 || (pc_src == 1 && branch_taken)) o = 7'b0110000;
    else                             o = 7'b0000000;
    req   = irq || pend;
    take  = req && !id_noirq && !ctrl && !stall && !lu && pc_src < 4;
    o[0]  = take;
    nage  = stall ? age + 1 : 0;
    npend = req && !take;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge and compare both instances with the model.
  task automatic step(input string tag);
    logic [6:0] ea, eb;
    @(negedge clk);
    ea = model(1, 3, age_a, pend_a, nage_a, npend_a);
    eb = model(2, 2, age_b, pend_b, nage_b, npend_b);
    chk({tag, "_a"}, pack_a, ea);
    chk({tag, "_b"}, pack_b, eb);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    age_a = nage_a; pend_a = npend_a;
    age_b = nage_b; pend_b = npend_b;
  endtask

  task automatic idle();
    reset = 0; opcode = 6'h23; funct = 0; pc_src = 0; branch_taken = 0;
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; ex_rt = 0; ex_mem_rd = 0;
    mem_rt = 0; mem_mem_rd = 0; mem_access = 0; irq = 0; id_noirq = 0;
  endtask

  initial begin
    idle();
    reset = 1; irq = 1; mem_access = 1;
    step("rst0"); chk("rst0_c", pack_a, 7'd0); adv();
    step("rst1"); adv();

    // Reset mid-wait with irq high
    reset = 0; irq = 0; mem_access = 1;
    step("pre_rst"); chk("pre_rst_c", pack_a, 7'b1000110); adv();
    reset = 1; irq = 1;
    step("rst_wait"); chk("rst_wait_c", pack_a, 7'd0); adv();
    idle();
    step("post_rst"); chk("post_rst_a", pack_a, 7'd0); chk("post_rst_b", pack_b, 7'd0); adv();

    // Wait states: 3-cycle stall, release, then an immediately following access
    idle(); mem_access = 1;
    for (int i = 0; i < 8; i++) begin
      step("ws");
      chk("ws_hold", {6'd0, a_eh}, (i == 3 || i == 7) ? 7'd0 : 7'd1);
      adv();
    end
    idle(); step("ws_done"); adv();

    // Load-use in EX, then against r0
    ex_mem_rd = 1; ex_rt = 8; id_rs = 8; id_use_rs = 1;
    step("lu_ex"); chk("lu_ex_c", pack_a, 7'b1001100); adv();
    ex_rt = 0; id_rs = 0;
    step("lu_r0"); chk("lu_r0_c", pack_a, 7'd0); adv();

    // Load-use in MEM is only seen by the depth-2 instance
    idle(); mem_mem_rd = 1; mem_rt = 5; id_rt = 5; id_use_rt = 1;
    step("lu_mem"); chk("lu_mem_b", pack_b, 7'b1001100); chk("lu_mem_a", pack_a, 7'd0); adv();

    // Interrupt arriving on a taken branch is held and taken on the next cycle
    idle(); pc_src = 1; branch_taken = 1; opcode = 6'h04; irq = 1;
    step("irq_br"); chk("irq_br_c", pack_a, 7'b0110000); adv();
    idle();
    step("irq_take"); chk("irq_take_c", pack_a, 7'b0000001); adv();
    step("irq_clr"); chk("irq_clr_c", pack_a, 7'd0); adv();

    // Exception deferred behind a 2-cycle memory wait
    idle(); pc_src = 5; mem_access = 1;
    for (int i = 0; i < 3; i++) begin
      step("exc");
      chk("exc_b", pack_b, (i < 2) ? 7'b1000110 : 7'b0100000);
      adv();
    end
    idle();
    for (int i = 0; i < 4; i++) begin step("settle"); adv(); end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 49) == 0);
      opcode       = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 9)) : 6'h23;
      funct        = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(8, 9)) : 6'h20;
      pc_src       = 3'($urandom_range(0, 5));
      branch_taken = 1'($urandom);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_use_rs    = 1'($urandom);
      id_use_rt    = 1'($urandom);
      ex_rt        = 5'($urandom_range(0, 3));
      ex_mem_rd    = ($urandom_range(0, 2) == 0);
      mem_rt       = 5'($urandom_range(0, 3));
      mem_mem_rd   = ($urandom_range(0, 2) == 0);
      mem_access   = ($urandom_range(0, 2) != 0);
      irq          = ($urandom_range(0, 3) == 0);
      id_noirq     = ($urandom_range(0, 3) == 0);
      step("rnd");
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
